// File: rtl/pkt_router_pipe.sv
// pkt_router_pipe
//
// Single-stage packet router. A ternary key/mask table (entry 0 has the
// highest priority) picks an output channel for each input packet. The
// winning route is captured into a one-entry stage register together with the
// packet.
//
// A missed packet is discarded in the following cycle. A hit packet is
// offered on its channel until that channel is ready. If the channel stays
// blocked for reg_drop_wait_in cycles, the packet is dropped; a value of 0
// disables dropping. Three saturating counters track delivered, unrouted and
// dropped packets.
//
// Ports
//   clk               clock
//   resetn            synchronous active-low reset
//   reg_key_in        per-entry keys, entry e at [e*KEY_BITS +: KEY_BITS]
//   reg_mask_in       per-entry masks, same layout as the keys
//   reg_route_in      per-entry channel, entry e at [e*ROUTE_BITS +: ROUTE_BITS]
//   reg_rvld_in       per-entry enable
//   reg_drop_wait_in  blocked cycles before drop (0 = never drop)
//   reg_cnt_clr_in    clears all statistics counters
//   pkt_in_*          input packet handshake
//   pkt_out_*         per-channel output handshake; data broadcast to all channels
//   cnt_*_out         statistics counters
module pkt_router_pipe #(
    parameter int unsigned PACKET_BITS  = 72,
    parameter int unsigned KEY_LSB      = 8,
    parameter int unsigned KEY_BITS     = 32,
    parameter int unsigned NUM_RREGS    = 16,
    parameter int unsigned NUM_CHANNELS = 8,
    parameter int unsigned ROUTE_BITS   = $clog2(NUM_CHANNELS),
    parameter int unsigned CNT_BITS     = 32,
    parameter int unsigned WAIT_BITS    = 16
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic [KEY_BITS*NUM_RREGS-1:0]       reg_key_in,
    input  logic [KEY_BITS*NUM_RREGS-1:0]       reg_mask_in,
    input  logic [ROUTE_BITS*NUM_RREGS-1:0]     reg_route_in,
    input  logic [NUM_RREGS-1:0]                reg_rvld_in,
    input  logic [WAIT_BITS-1:0]                reg_drop_wait_in,
    input  logic                                reg_cnt_clr_in,
    input  logic [PACKET_BITS-1:0]              pkt_in_data_in,
    input  logic                                pkt_in_vld_in,
    output logic                                pkt_in_rdy_out,
    output logic [PACKET_BITS*NUM_CHANNELS-1:0] pkt_out_data_out,
    output logic [NUM_CHANNELS-1:0]             pkt_out_vld_out,
    input  logic [NUM_CHANNELS-1:0]             pkt_out_rdy_in,
    output logic [CNT_BITS-1:0]                 cnt_routed_out,
    output logic [CNT_BITS-1:0]                 cnt_unrouted_out,
    output logic [CNT_BITS-1:0]                 cnt_dropped_out
);

    localparam logic [1:0] StEmpty    = 2'd0;
    localparam logic [1:0] StHoldHit  = 2'd1;
    localparam logic [1:0] StHoldMiss = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [PACKET_BITS-1:0] data_q, data_d;
    logic [ROUTE_BITS-1:0]  route_q, route_d;
    logic [WAIT_BITS-1:0]   wait_q, wait_d;
    logic [CNT_BITS-1:0]    cnt_routed_q, cnt_routed_d;
    logic [CNT_BITS-1:0]    cnt_unrouted_q, cnt_unrouted_d;
    logic [CNT_BITS-1:0]    cnt_dropped_q, cnt_dropped_d;

    // ------------------------------------------------------------------
    // Table lookup (combinational on the input packet)
    // ------------------------------------------------------------------
    logic [KEY_BITS-1:0]   lk_key;
    logic                  lk_hit;
    logic [ROUTE_BITS-1:0] lk_route;
    logic                  lk_route_ok;

    assign lk_key = pkt_in_data_in[KEY_LSB +: KEY_BITS];

    // Walk from the highest index down so the lowest-index hit is the last
    // assignment and therefore wins.
    always_comb begin
        lk_hit   = 1'b0;
        lk_route = '0;
        for (int e = int'(NUM_RREGS) - 1; e >= 0; e--) begin
            if (reg_rvld_in[e] &&
                ((lk_key & reg_mask_in[e*KEY_BITS +: KEY_BITS]) ==
                 reg_key_in[e*KEY_BITS +: KEY_BITS])) begin
                lk_hit   = 1'b1;
                lk_route = reg_route_in[e*ROUTE_BITS +: ROUTE_BITS];
            end
        end
    end

    // Routes that name a non-existent channel are treated as misses. The
    // check is only needed when the route field can encode such values.
    generate
        if ((2 ** ROUTE_BITS) > NUM_CHANNELS) begin : g_route_chk
            assign lk_route_ok = (32'(lk_route) < NUM_CHANNELS);
        end else begin : g_route_nochk
            assign lk_route_ok = 1'b1;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage control
    // ------------------------------------------------------------------
    logic out_rdy;
    logic deliver;
    logic drop;
    logic discard_miss;
    logic leave;
    logic accept;

    assign out_rdy      = pkt_out_rdy_in[route_q];
    assign deliver      = (state_q == StHoldHit) && out_rdy;
    // ">=" rather than "==" so a threshold lowered below the current count
    // still drops on the next blocked cycle.
    assign drop         = (state_q == StHoldHit) && !out_rdy &&
                          (reg_drop_wait_in != '0) && (wait_q >= reg_drop_wait_in);
    assign discard_miss = (state_q == StHoldMiss);
    assign leave        = deliver || drop || discard_miss;

    assign pkt_in_rdy_out = resetn && ((state_q == StEmpty) || leave);
    assign accept         = pkt_in_vld_in && pkt_in_rdy_out;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        route_d = route_q;
        wait_d  = wait_q;
        if (accept) begin
            state_d = (lk_hit && lk_route_ok) ? StHoldHit : StHoldMiss;
            data_d  = pkt_in_data_in;
            route_d = lk_route;
            wait_d  = '0;
        end else if (leave) begin
            state_d = StEmpty;
            wait_d  = '0;
        end else if (state_q == StHoldHit) begin
            // Saturate so a never-dropping blocked packet cannot wrap.
            wait_d = (wait_q == '1) ? wait_q : wait_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Statistics counters (saturating; clear beats increment)
    // ------------------------------------------------------------------
    function automatic logic [CNT_BITS-1:0] cnt_next(input logic [CNT_BITS-1:0] cur,
                                                     input logic inc,
                                                     input logic clr);
        if (clr) begin
            return '0;
        end else if (inc && (cur != '1)) begin
            return cur + 1'b1;
        end
        return cur;
    endfunction

    always_comb begin
        cnt_routed_d   = cnt_next(cnt_routed_q, deliver, reg_cnt_clr_in);
        cnt_unrouted_d = cnt_next(cnt_unrouted_q, discard_miss, reg_cnt_clr_in);
        cnt_dropped_d  = cnt_next(cnt_dropped_q, drop, reg_cnt_clr_in);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= StEmpty;
            data_q         <= '0;
            route_q        <= '0;
            wait_q         <= '0;
            cnt_routed_q   <= '0;
            cnt_unrouted_q <= '0;
            cnt_dropped_q  <= '0;
        end else begin
            state_q        <= state_d;
            data_q         <= data_d;
            route_q        <= route_d;
            wait_q         <= wait_d;
            cnt_routed_q   <= cnt_routed_d;
            cnt_unrouted_q <= cnt_unrouted_d;
            cnt_dropped_q  <= cnt_dropped_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (valid depends on stage state only)
    // ------------------------------------------------------------------
    always_comb begin
        pkt_out_vld_out = '0;
        if (state_q == StHoldHit) begin
            pkt_out_vld_out[route_q] = 1'b1;
        end
    end

    assign pkt_out_data_out = {NUM_CHANNELS{data_q}};
    assign cnt_routed_out   = cnt_routed_q;
    assign cnt_unrouted_out = cnt_unrouted_q;
    assign cnt_dropped_out  = cnt_dropped_q;

endmodule
